seg_display_scan: RTL and testbench

//  Downstream stage of the watch controller: takes the binary Sec/Min/Hr (or Day/Mon/Year)

---
 rtl/seg_display_scan_pkg.sv | 37 +++
 rtl/seg_display_scan_if.sv | 13 +
 rtl/seg_display_scan_seg7_decode.sv | 24 ++
 rtl/seg_display_scan.sv | 104 ++++++++++
 tb/tb_seg_display_scan.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/seg_display_scan_pkg.sv
// Shared constants, types and the binary-to-BCD helper for the 7-digit scan driver.
package seg_display_scan_pkg;

    localparam int SCAN_DIV   = 32;
    localparam int BLANK_CYC  = 2;
    localparam int BLINK_DIV  = 16384;
    localparam int NUM_DIGITS = 7;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        BLINK_NONE = 2'b00,
        BLINK_SEC  = 2'b01,
        BLINK_MIN  = 2'b10,
        BLINK_HR   = 2'b11
    } blink_t;

    typedef struct packed {
        logic [7:0] sec;
        logic [7:0] min;
        logic [7:0] hr;
        logic [3:0] week;
        blink_t     blink;
    } frame_t;

    // {tens, units}; out-of-range values return 4'hF in both nibbles, which decodes to a dash.
    function automatic logic [7:0] to_bcd(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] u;
        if (v > 8'd99) return 8'hFF;
        t = 4'(v / 8'd10);
        u = 4'(v % 8'd10);
        return {t, u};
    endfunction

endpackage

// File: rtl/seg_display_scan_if.sv
// Field buffers from the watch controller plus the multiplexed display drive.
interface seg_display_scan_if;
    logic [1:0] Blink;
    logic [7:0] SecBuffer;
    logic [7:0] MinBuffer;
    logic [7:0] HrBuffer;
    logic [3:0] Week;
    logic [7:0] Seg;
    logic [6:0] Dig;

    modport master (output Blink, SecBuffer, MinBuffer, HrBuffer, Week, input Seg, Dig);
    modport slave  (input Blink, SecBuffer, MinBuffer, HrBuffer, Week, output Seg, Dig);
endinterface

// File: rtl/seg_display_scan_seg7_decode.sv
// BCD to active-low {g..a}; codes 10..15 show a dash.
module seg7_decode
    import seg_display_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = 7'h40;
            4'd1: seg = 7'h79;
            4'd2: seg = 7'h24;
            4'd3: seg = 7'h30;
            4'd4: seg = 7'h19;
            4'd5: seg = 7'h12;
            4'd6: seg = 7'h02;
            4'd7: seg = 7'h78;
            4'd8: seg = 7'h00;
            4'd9: seg = 7'h10;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/seg_display_scan.sv
// Time-multiplexes HH MM SS W onto a 7-digit common-anode display with
// per-frame snapshots, inter-digit blanking and 1 Hz field/separator blink.
module seg_display_scan
    import seg_display_scan_pkg::*;
#(
    parameter int SCAN_DIV_P  = SCAN_DIV,
    parameter int BLANK_CYC_P = BLANK_CYC,
    parameter int BLINK_DIV_P = BLINK_DIV
)(
    input  logic               clk_32_768K,
    input  logic               rst,
    seg_display_scan_if.slave  bus
);
    localparam int SLOT_W  = $clog2(SCAN_DIV_P);
    localparam int BLINK_W = $clog2(BLINK_DIV_P);

    logic [SLOT_W-1:0]  slot_cnt;
    logic [2:0]         dig_idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;
    logic               first_slot;
    frame_t             snap;
    frame_t             live;
    frame_t             frame;
    logic [7:0]         seg_q;
    logic [6:0]         dig_q;

    logic               slot_wrap;
    logic               frame_wrap;
    logic [7:0]         bcd_hr;
    logic [7:0]         bcd_min;
    logic [7:0]         bcd_sec;
    logic [3:0]         digit_code;
    logic               field_blinks;
    logic [6:0]         glyph;
    logic [7:0]         seg_nxt;
    logic [6:0]         dig_nxt;

    assign live       = {bus.SecBuffer, bus.MinBuffer, bus.HrBuffer, bus.Week, blink_t'(bus.Blink)};
    assign slot_wrap  = (slot_cnt == SLOT_W'(SCAN_DIV_P - 1));
    assign frame_wrap = slot_wrap && (dig_idx == 3'(NUM_DIGITS - 1));
    // The very first slot after reset has no snapshot yet, so it reads the live buffers.
    assign frame      = first_slot ? live : snap;

    assign bcd_hr  = to_bcd(frame.hr);
    assign bcd_min = to_bcd(frame.min);
    assign bcd_sec = to_bcd(frame.sec);

    always_comb begin
        digit_code   = 4'hF;
        field_blinks = 1'b0;
        case (dig_idx)
            3'd0: begin digit_code = bcd_hr[7:4];  field_blinks = (frame.blink == BLINK_HR);  end
            3'd1: begin digit_code = bcd_hr[3:0];  field_blinks = (frame.blink == BLINK_HR);  end
            3'd2: begin digit_code = bcd_min[7:4]; field_blinks = (frame.blink == BLINK_MIN); end
            3'd3: begin digit_code = bcd_min[3:0]; field_blinks = (frame.blink == BLINK_MIN); end
            3'd4: begin digit_code = bcd_sec[7:4]; field_blinks = (frame.blink == BLINK_SEC); end
            3'd5: begin digit_code = bcd_sec[3:0]; field_blinks = (frame.blink == BLINK_SEC); end
            3'd6: digit_code = (frame.week >= 4'd1 && frame.week <= 4'd7) ? frame.week : 4'hF;
            default: begin digit_code = 4'hF; field_blinks = 1'b0; end
        endcase
    end

    seg7_decode u_dec (
        .bcd (digit_code),
        .seg (glyph)
    );

    always_comb begin
        seg_nxt[6:0] = (!blink_on && field_blinks) ? SEG_BLANK : glyph;
        seg_nxt[7]   = ~(blink_on && (dig_idx == 3'd1 || dig_idx == 3'd3));
        dig_nxt      = (slot_cnt < SLOT_W'(BLANK_CYC_P)) ? 7'h7F : ~(7'd1 << dig_idx);
    end

    always_ff @(posedge clk_32_768K or posedge rst) begin
        if (rst) begin
            slot_cnt   <= '0;
            dig_idx    <= '0;
            blink_cnt  <= '0;
            blink_on   <= 1'b1;
            first_slot <= 1'b1;
            snap       <= '0;
            seg_q      <= 8'hFF;
            dig_q      <= 7'h7F;
        end else begin
            first_slot <= 1'b0;
            slot_cnt   <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap) dig_idx <= frame_wrap ? 3'd0 : dig_idx + 3'd1;
            if (blink_cnt == BLINK_W'(BLINK_DIV_P - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            if (first_slot || frame_wrap) snap <= live;
            seg_q <= seg_nxt;
            dig_q <= dig_nxt;
        end
    end

    assign bus.Seg = seg_q;
    assign bus.Dig = dig_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan: per-cycle comparison against a frame/slot arithmetic model.
module tb_seg_display_scan;
    localparam int SCAN  = 32;
    localparam int BLANK = 2;
    localparam int BDIV  = 16384;
    localparam int FRAME = 7 * SCAN;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg_display_scan_if bus();

    seg_display_scan #(.SCAN_DIV_P(SCAN), .BLANK_CYC_P(BLANK), .BLINK_DIV_P(BDIV)) dut (
        .clk_32_768K (clk),
        .rst         (rst),
        .bus         (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model state: edges since reset release, and the frame snapshot seen by the display.
    int         edges = 0;
    int         m_sec, m_min, m_hr, m_week, m_blink;
    logic [7:0] exp_seg = 8'hFF;
    logic [6:0] exp_dig = 7'h7F;

    logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [6:0] digit_glyph(input int d);
        if (d < 0 || d > 9) return 7'h3F;
        return glyph[d];
    endfunction

    // Display state at time tt (tt = clocks since reset release).
    function automatic logic [14:0] expect_at(input int tt);
        int slot, idx, val, d, field;
        bit on, blanked;
        logic [6:0] g, dg;
        logic [7:0] s;
        slot = tt % SCAN;
        idx  = (tt / SCAN) % 7;
        on   = ((tt / BDIV) % 2) == 0;
        blanked = 1'b0;
        if (idx < 6) begin
            field = idx / 2;
            val = (field == 0) ? m_hr : (field == 1) ? m_min : m_sec;
            if (val > 99) d = -1;
            else d = (idx % 2 == 0) ? val / 10 : val % 10;
            blanked = !on && ((field == 0 && m_blink == 3) ||
                              (field == 1 && m_blink == 2) ||
                              (field == 2 && m_blink == 1));
        end else begin
            d = (m_week >= 1 && m_week <= 7) ? m_week : -1;
        end
        g  = blanked ? 7'h7F : digit_glyph(d);
        s  = {!(on && (idx == 1 || idx == 3)), g};
        dg = (slot < BLANK) ? 7'h7F : (7'h7F & ~(7'd1 << idx));
        return {s, dg};
    endfunction

    task automatic capture();
        m_sec   = int'(bus.SecBuffer);
        m_min   = int'(bus.MinBuffer);
        m_hr    = int'(bus.HrBuffer);
        m_week  = int'(bus.Week);
        m_blink = int'(bus.Blink);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edges   = 0;
            exp_seg = 8'hFF;
            exp_dig = 7'h7F;
        end else begin
            edges++;
            if (edges == 1) capture();
            {exp_seg, exp_dig} = expect_at(edges - 1);
            if ((edges - 1) % FRAME == FRAME - 1) capture();
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1 || edges > 0) begin
            checks++;
            if (bus.Seg !== exp_seg || bus.Dig !== exp_dig) begin
                errors++;
                if (errors < 20)
                    $display("FAIL model t=%0d seg=%h dig=%h want seg=%h dig=%h",
                             edges, bus.Seg, bus.Dig, exp_seg, exp_dig);
            end
            checks++;
            if (!(bus.Dig === 7'h7F || $onehot(~bus.Dig))) begin
                errors++;
                $display("FAIL dig_onehot dig=%h want one-hot-low or 7f", bus.Dig);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    task automatic wait_dig(input logic [6:0] d, input string name);
        int n = 0;
        while (bus.Dig !== d && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL timeout_%s got dig=%h want %h", name, bus.Dig, d);
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        bus.HrBuffer  = 8'd12;
        bus.MinBuffer = 8'd34;
        bus.SecBuffer = 8'd56;
        bus.Week      = 4'd3;
        bus.Blink     = 2'b00;
        #1 rst = 1'b1;
        run_cycles(3);
        check("reset_seg", bus.Seg, 8'hFF);
        check("reset_dig", {1'b0, bus.Dig}, 8'h7F);
        rst = 1'b0;

        // static frame 12 34 56 3
        wait_dig(7'h7E, "d0");  check("static_d0", bus.Seg, 8'hF9);
        wait_dig(7'h7D, "d1");  check("static_d1_dp", bus.Seg, 8'h24);
        wait_dig(7'h3F, "d6");  check("static_week", bus.Seg, 8'hB0);

        // blink minutes across OFF and back to ON
        bus.Blink = 2'b10;
        while (edges < BDIV + 2 * FRAME) @(negedge clk);
        wait_dig(7'h7D, "off_d1"); check("off_d1_nodp", bus.Seg, 8'hA4);
        wait_dig(7'h7B, "off_d2"); check("off_min_tens", bus.Seg, 8'hFF);
        wait_dig(7'h77, "off_d3"); check("off_min_units", bus.Seg, 8'hFF);
        while (edges < 2 * BDIV + 2 * FRAME) @(negedge clk);
        wait_dig(7'h77, "on_d3");  check("on_min_units_dp", bus.Seg, 8'h19);

        // out-of-range seconds and weekday
        bus.Blink     = 2'b00;
        bus.SecBuffer = 8'd150;
        bus.Week      = 4'd0;
        run_cycles(2 * FRAME);
        wait_dig(7'h6F, "dash4"); check("dash_sec_tens", bus.Seg, 8'hBF);
        wait_dig(7'h5F, "dash5"); check("dash_sec_units", bus.Seg, 8'hBF);
        wait_dig(7'h3F, "dash6"); check("dash_week", bus.Seg, 8'hBF);
        bus.SecBuffer = 8'd99;
        run_cycles(FRAME + 1);
        wait_dig(7'h6F, "s99");   check("sec_99", bus.Seg, 8'h90);

        // hour change while digit 3 is lit; remainder of frame checked by the model
        wait_dig(7'h77, "tear3");
        bus.HrBuffer = 8'd23;
        wait_dig(7'h7E, "tear0"); check("next_frame_hr", bus.Seg, 8'hA4);

        // async reset during digit 4
        wait_dig(7'h6F, "rst4");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_seg", bus.Seg, 8'hFF);
        check("async_dig", {1'b0, bus.Dig}, 8'h7F);
        run_cycles(3);
        rst = 1'b0;
        n = 0;
        while (bus.Dig !== 7'h7E && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("restart_first_dig0", 8'(n), 8'(BLANK + 1));

        // random buffers, model checks every cycle
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0) begin
                bus.SecBuffer = 8'($urandom_range(0, 120));
                bus.MinBuffer = 8'($urandom_range(0, 120));
                bus.HrBuffer  = 8'($urandom_range(0, 120));
                bus.Week      = 4'($urandom_range(0, 15));
                bus.Blink     = 2'($urandom_range(0, 3));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
